bcd_counter_display: RTL and testbench
======================================

Name: bcd_counter_display

Overview:
- Parametrised successor to the single-digit 0–15 counter/7-segment top level.
- N-digit BCD up/down counter with prescaled count tick, synchronous load, and wrap/saturate mode.
- Drives a time-multiplexed common 7-segment bus (seg plus one-hot digit select).
- Sits between board clock/switches and the display pins of the lab top module.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8).
- TICK_DIV, 50_000_000, clk cycles per count tick (>=1; 1 = tick every enabled cycle).
- SCAN_DIV, 50_000, clk cycles each digit is held on the bus (>=1).
- SEG_ACTIVE_LOW, 1, 1 = seg and digit_sel driven active-low; 0 = active-high.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; prescaler runs only while high.
- up_down  input  1  1 = count up, 0 = count down.
- wrap_en  input  1  1 = wrap at limit, 0 = saturate at limit.
- load  input  1  synchronous load strobe.
- load_value  input  4*NUM_DIGITS  BCD load value; digit 0 in bits [3:0].
- count  output  4*NUM_DIGITS  registered BCD count.
- at_limit  output  1  level: count is all-9 (up_down=1) or all-0 (up_down=0); combinational from count and up_down.
- rollover  output  1  one-cycle registered pulse on a wrap event.
- seg  output  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- digit_sel  output  NUM_DIGITS  one-hot digit enable; bit 0 = least significant digit.

Behaviour:
- Reset (reset=0, async): count=0, prescaler=0, scan counter=0, digit index=0, rollover=0, seg=blank, digit_sel=all off. Blank/off means all 1 when SEG_ACTIVE_LOW=1, all 0 otherwise.
- Prescaler: cleared when en=0 or load=1; otherwise increments and returns to 0 at TICK_DIV-1. tick = en & ~load & (prescaler==TICK_DIV-1).
- Priority per cycle: load > tick > hold.
- Load: count <= load_value next edge. Any digit >9 is clamped to 9. rollover=0.
- Tick, up: BCD increment with per-digit carry (9→0 carries).
  - At all-9 with wrap_en=1: count <= 0, rollover=1 next cycle.
  - At all-9 with wrap_en=0: count holds, rollover=0.
- Tick, down: BCD decrement with per-digit borrow (0→9 borrows).
  - At all-0 with wrap_en=1: count <= all-9, rollover=1.
  - At all-0 with wrap_en=0: count holds.
- up_down or wrap_en changes take effect on the next tick; no pending state.
- rollover is high exactly one cycle per wrap event and is 0 on every cycle without a wrap tick.
- Scan: scan counter counts 0..SCAN_DIV-1 continuously, independent of en. At terminal value, digit index advances modulo NUM_DIGITS (NUM_DIGITS-1 → 0).
- Display register: every cycle, seg <= decode(count digit[index]) and digit_sel <= onehot(index), each inverted when SEG_ACTIVE_LOW=1. This gives one-cycle latency from index/count change to pins.
  - First valid display appears 1 cycle after reset release (digit 0, "0").
- Decode, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Codes >9 cannot occur; decoder default = blank.
- Reset asserted mid-count or mid-scan: immediate return to reset values, no partial update.

Decomposition:
- Package bcd_display_pkg holds:
  - SEG7 constant array (10 x 7 bits) and SEG_BLANK.
  - BCD_MAX=4'd9.
  - Function bcd_to_seg(digit) returning the active-high pattern.
  - Function bcd_clamp(digit).
- Sub-module bcd_digit_cell, instantiated NUM_DIGITS times in a generate chain.
  - Inputs: 4-bit register, inc/dec enable, carry-in/borrow-in.
  - Outputs: carry-out/borrow-out, is_nine, is_zero.
  - Top level handles prescaler, limit/wrap control, scan and the output register.

Test Plan (NUM_DIGITS=2, TICK_DIV=2, SCAN_DIV=4, SEG_ACTIVE_LOW=1):
- Reset release, en=0 -> count=8'h00, seg=7'h7F, digit_sel=2'b11 during reset. 1 cycle after release: seg=7'h40 ("0"), digit_sel=2'b10. Count does not change.
- load_value=8'h10, load, then en=1, up_down=0, wrap_en=1 -> count goes 10,09,08 with one step every 2 cycles. At_limit=1 when count reaches 00. Next tick gives 99 with rollover high for exactly 1 cycle.
- wrap_en=0, up_down=1, load 8'h98, en=1 -> count goes 98, 99. at_limit=1, count stays 99 on later ticks, rollover never asserts.
- load_value=8'hFA -> count=8'h99 (both digits clamped). load asserted together with a tick -> load wins and the prescaler restarts from 0.
- count=8'h42, en=0 -> digit_sel alternates 2'b10/2'b01 every 4 cycles. seg=7'h24 ("2") while digit 0 is selected and 7'h19 ("4") while digit 1 is selected.
- Reset pulsed low mid-count at count=8'h57 -> outputs return to reset values asynchronously (no clk edge needed). Counting resumes from 00 after release.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared constants and helpers for the BCD counter and its 7-segment display.
package bcd_display_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high patterns {g,f,e,d,c,b,a}, element 0 is the digit "0".
    localparam logic [9:0][6:0] SEG7 = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        if (digit > BCD_MAX) begin
            return SEG_BLANK;
        end
        return SEG7[digit];
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter chain: next value plus carry/borrow for the digit above.
module bcd_digit_cell
    import bcd_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_up,
    input  logic       i_cin,
    output logic [3:0] o_next,
    output logic       o_cout,
    output logic       o_is_nine,
    output logic       o_is_zero
);

    always_comb begin
        o_is_nine = (i_digit == BCD_MAX);
        o_is_zero = (i_digit == 4'd0);
        o_next    = i_digit;
        if (i_cin) begin
            if (i_up) begin
                o_next = o_is_nine ? 4'd0 : i_digit + 4'd1;
            end else begin
                o_next = o_is_zero ? BCD_MAX : i_digit - 4'd1;
            end
        end
        // Carry (up) or borrow (down) ripples only through saturated digits.
        o_cout = i_cin & (i_up ? o_is_nine : o_is_zero);
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaled tick, load, wrap/saturate and a
// time-multiplexed 7-segment output stage.
module bcd_counter_display
    import bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TICK_DIV       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up_down,
    input  logic                    wrap_en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    at_limit,
    output logic                    rollover,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_POL = (SEG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_presc;
    logic [SW-1:0]         r_scan;
    logic [IW-1:0]         r_idx;
    logic                  r_rollover;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_sel;

    logic [CW-1:0]         w_next;
    logic [CW-1:0]         w_load_clamped;
    logic [NUM_DIGITS:0]   w_carry;
    logic [NUM_DIGITS-1:0] w_is_nine;
    logic [NUM_DIGITS-1:0] w_is_zero;
    logic [3:0]            w_digit [NUM_DIGITS];
    logic [3:0]            w_cur_digit;
    logic                  w_tick;
    logic                  w_presc_last;
    logic                  w_limit_hit;

    // The chain always computes the stepped value; it is only committed on a tick.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .i_digit   (r_count[4*gi +: 4]),
                .i_up      (up_down),
                .i_cin     (w_carry[gi]),
                .o_next    (w_next[4*gi +: 4]),
                .o_cout    (w_carry[gi+1]),
                .o_is_nine (w_is_nine[gi]),
                .o_is_zero (w_is_zero[gi])
            );
            assign w_load_clamped[4*gi +: 4] = bcd_clamp(load_value[4*gi +: 4]);
            assign w_digit[gi]               = r_count[4*gi +: 4];
        end
    endgenerate

    assign w_presc_last = (r_presc == PRESC_LAST);
    assign w_tick       = en & ~load & w_presc_last;
    // Carry out of the top digit means every digit is at the limit for this direction.
    assign w_limit_hit  = w_carry[NUM_DIGITS];
    assign w_cur_digit  = w_digit[r_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_rollover <= 1'b0;
        end else begin
            if (!en || load || w_presc_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end

            r_rollover <= 1'b0;
            if (load) begin
                r_count <= w_load_clamped;
            end else if (w_tick) begin
                if (!w_limit_hit || wrap_en) begin
                    r_count <= w_next;
                end
                r_rollover <= w_limit_hit & wrap_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= SEG_BLANK ^ SEG_POL;
            r_sel  <= SEL_POL;
        end else begin
            if (r_scan == SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan <= r_scan + SW'(1);
            end
            r_seg <= bcd_to_seg(w_cur_digit) ^ SEG_POL;
            r_sel <= (NUM_DIGITS'(1) << r_idx) ^ SEL_POL;
        end
    end

    assign count     = r_count;
    assign at_limit  = up_down ? (&w_is_nine) : (&w_is_zero);
    assign rollover  = r_rollover;
    assign seg       = r_seg;
    assign digit_sel = r_sel;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Randomized and directed checks of bcd_counter_display against a decimal reference model.
module tb_bcd_counter_display;

    localparam int ND   = 2;
    localparam int TDIV = 2;
    localparam int SDIV = 4;
    localparam int MAXV = 99;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            en = 1'b0;
    logic            up_down = 1'b0;
    logic            wrap_en = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] load_value = '0;
    logic [4*ND-1:0] count;
    logic            at_limit;
    logic            rollover;
    logic [6:0]      seg;
    logic [ND-1:0]   digit_sel;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: count held as a plain decimal integer.
    int         m_count, m_presc, m_scan, m_idx;
    bit         m_roll;
    logic [6:0] m_seg;
    logic [1:0] m_sel;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_counter_display #(
        .NUM_DIGITS     (ND),
        .TICK_DIV       (TDIV),
        .SCAN_DIV       (SDIV),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down    (up_down),
        .wrap_en    (wrap_en),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .at_limit   (at_limit),
        .rollover   (rollover),
        .seg        (seg),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_load(input logic [7:0] lv);
        int lo, hi;
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_scan = 0; m_idx = 0;
        m_roll  = 1'b0;
        m_seg   = 7'h7F;
        m_sel   = 2'b11;
    endtask

    task automatic model_step(input bit en_i, input bit ud_i, input bit wr_i,
                              input bit ld_i, input logic [7:0] lv_i);
        int  c_n, d;
        bit  tick, r_n;
        d    = (m_idx == 0) ? (m_count % 10) : (m_count / 10);
        tick = en_i && !ld_i && (m_presc == TDIV - 1);
        c_n  = m_count;
        r_n  = 1'b0;
        if (ld_i) begin
            c_n = clamp_load(lv_i);
        end else if (tick) begin
            if (ud_i) begin
                if (m_count == MAXV) begin
                    if (wr_i) begin c_n = 0; r_n = 1'b1; end
                end else begin
                    c_n = m_count + 1;
                end
            end else begin
                if (m_count == 0) begin
                    if (wr_i) begin c_n = MAXV; r_n = 1'b1; end
                end else begin
                    c_n = m_count - 1;
                end
            end
        end
        m_presc = (!en_i || ld_i || m_presc == TDIV - 1) ? 0 : m_presc + 1;
        m_seg   = ~seg_tab[d];
        m_sel   = ~(2'b01 << m_idx);
        if (m_scan == SDIV - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % ND;
        end else begin
            m_scan = m_scan + 1;
        end
        m_count = c_n;
        m_roll  = r_n;
    endtask

    // Called at a falling edge: drive, advance the model across one rising edge, compare.
    task automatic step(input bit en_i, input bit ud_i, input bit wr_i,
                        input bit ld_i, input logic [7:0] lv_i);
        int exp_lim;
        en = en_i; up_down = ud_i; wrap_en = wr_i; load = ld_i; load_value = lv_i;
        #1;
        exp_lim = ud_i ? int'(m_count == MAXV) : int'(m_count == 0);
        check("at_limit", 32'(at_limit), 32'(exp_lim));
        model_step(en_i, ud_i, wr_i, ld_i, lv_i);
        @(negedge clk);
        check("count", 32'(count), 32'(to_bcd(m_count)));
        check("rollover", 32'(rollover), 32'(m_roll));
        check("seg", 32'(seg), 32'(m_seg));
        check("digit_sel", 32'(digit_sel), 32'(m_sel));
        if (ld_i) $display("load %02h -> count %02h", lv_i, count);
        if (m_roll) $display("wrap -> count %02h rollover %0b", count, rollover);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'h00);
        check({tag, "_rollover"}, 32'(rollover), 32'h0);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_sel"}, 32'(digit_sel), 32'h3);
    endtask

    initial begin
        bit ud_r, wr_r;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b1;

        // Idle after release: first display "0" on digit 0, count frozen.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Count down through zero with wrap.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
        repeat (26) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Count up into saturation.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Clamping, then load colliding with a tick.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFA);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h35);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h61);
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

        // Scan with a frozen count.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset in the middle of a clock phase.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h57);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Randomized phase.
        ud_r = 1'b1;
        wr_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ud_r = ~ud_r;
            if ($urandom_range(0, 29) == 0) wr_r = ~wr_r;
            step(($urandom_range(0, 7) != 0), ud_r, wr_r,
                 ($urandom_range(0, 39) == 0), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
